cpu7_ifu_fetch_ctl: RTL and testbench
=====================================

Name: cpu7_ifu_fetch_ctl

Overview:
Fetch sequencer for the IFU. It owns the fetch address and pc_f, and issues 64-bit (two-instruction) line requests to the ICU. It filters returning ICU data into the instruction queue and handles branch redirects by flushing the queue and discarding stale in-flight responses. It sits between the EXU redirect/stall signals, the ICU request/ack/data interface, and the two-entry instruction queue.

Parameters:
RESET_PC, 32'h1c000000, address of first fetch and initial pc_f (bits [1:0] must be 0)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
exu_ifu_br_taken  in  1  single-cycle redirect pulse
exu_ifu_br_target  in  32  redirect PC
exu_ifu_stall_req  in  1  EXU stall; blocks pc_f advance
iq_not_empty  in  1  queue holds a valid line
fetch_ahead  in  1  queue permits the next line request
ifu_icu_req_ic1  out  1  fetch request
ifu_icu_addr_ic1  out  32  8-byte-aligned fetch address
icu_ifu_ack_ic1  in  1  request accepted
icu_ifu_data_valid_ic2  in  1  line returned from ICU
ifu_iq_data_valid  out  1  filtered data-valid to the queue
flush_iq  out  1  queue flush
pc_f  out  32  PC of the instruction currently presented

Behaviour:
- Clocking/reset: one clock, clk. resetn is asynchronous and active-low.
- Reset values:
  - state = BOOT; ifu_icu_req_ic1 = 0; drop = 0.
  - fetch_addr = {RESET_PC[31:3], 3'b0}; pc_f = RESET_PC.
  - flush_iq = 0; ifu_iq_data_valid = 0.
- States:
  - BOOT: one cycle, then REQ.
  - REQ: ifu_icu_req_ic1 = 1; ifu_icu_addr_ic1 = fetch_addr.
    - ack -> WAIT.
    - No ack -> stay in REQ. The address may change before ack only on redirect.
  - WAIT: request outstanding; req = 0.
    - data_valid & drop -> clear drop, go to REQ.
    - data_valid & ~drop & ~br_taken -> fetch_addr += 8, go to HOLD.
  - HOLD: line held in the queue.
    - fetch_ahead -> REQ.
    - ~iq_not_empty -> REQ (queue drained).
- Exactly one request outstanding at any time; no new req in WAIT.
- ifu_iq_data_valid = data_valid & (state==WAIT) & ~drop & ~exu_ifu_br_taken. Combinational, zero latency.
- flush_iq = exu_ifu_br_taken. Combinational, same cycle as the pulse.
- Redirect (br_taken), registered at the clock edge:
  - pc_f <= {target[31:2], 2'b0}.
  - fetch_addr <= {target[31:3], 3'b0}.
  - REQ without ack: stay in REQ; the new address is visible the next cycle.
  - REQ with ack same cycle: go to WAIT with drop = 1.
  - WAIT, no data_valid: drop <= 1, stay in WAIT.
  - WAIT with data_valid same cycle: data is suppressed, drop stays 0, go to REQ.
  - HOLD: go to REQ.
  - Redirect while drop is already set: drop stays 1, and the target is overwritten by the newest redirect.
- pc_f advance: pc_f += 4 when iq_not_empty & ~exu_ifu_stall_req & ~br_taken. Redirect has priority.
- Arithmetic: 32-bit; fetch_addr and pc_f wrap modulo 2^32. No carry out and no error is raised.
- Reset asserted mid-operation returns everything to reset values immediately. An outstanding ICU response that arrives after reset is dropped: the block is in BOOT/REQ, not WAIT.

Optional Feature:
CPU7_IFU_FETCH_PERF_EN
- Defined: adds two outputs, perf_fetch_cnt[31:0] and perf_drop_cnt[31:0], both reset to 0.
  - perf_fetch_cnt increments on each req & ack.
  - perf_drop_cnt increments on each suppressed data_valid (drop or same-cycle redirect).
  - Both counters wrap at 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Boot: release resetn, ack on the first req cycle, data_valid 2 cycles later.
  -> addr 0x1c000000, ifu_iq_data_valid = 1 once, state HOLD, next fetch_addr 0x1c000008.
- Sequential: iq_not_empty = 1, no stall, for 4 cycles from pc_f 0x1c000000 -> pc_f 0x1c000010.
  - With stall asserted the 2nd cycle -> 0x1c00000c.
- Redirect in WAIT: br_taken with target 0x1c000024 before data_valid.
  -> flush_iq = 1 that cycle; the later data_valid is suppressed (ifu_iq_data_valid = 0).
  -> next req addr 0x1c000020; pc_f 0x1c000024.
- Simultaneous data_valid and br_taken in WAIT -> ifu_iq_data_valid = 0, drop = 0, next req to the target line.
- Redirect in REQ with ack withheld -> req stays high, and the addr switches to the target line the next cycle.
- Reset asserted during WAIT -> outputs return to reset values asynchronously; after release the first addr is 0x1c000000.

Source files
------------

// File: rtl/cpu7_ifu_fetch_ctl_if.sv
// ICU fetch handshake bundle.
//   ifu_icu_req_ic1        IFU -> ICU  fetch request
//   ifu_icu_addr_ic1[31:0] IFU -> ICU  8-byte-aligned line address
//   icu_ifu_ack_ic1        ICU -> IFU  request accepted
//   icu_ifu_data_valid_ic2 ICU -> IFU  line returned
interface cpu7_ifu_fetch_ctl_if;
  logic        ifu_icu_req_ic1;
  logic [31:0] ifu_icu_addr_ic1;
  logic        icu_ifu_ack_ic1;
  logic        icu_ifu_data_valid_ic2;

  modport master (
    output ifu_icu_req_ic1, ifu_icu_addr_ic1,
    input  icu_ifu_ack_ic1, icu_ifu_data_valid_ic2
  );

  modport slave (
    input  ifu_icu_req_ic1, ifu_icu_addr_ic1,
    output icu_ifu_ack_ic1, icu_ifu_data_valid_ic2
  );
endinterface

// File: rtl/cpu7_ifu_fetch_ctl.sv
// IFU fetch sequencer: owns fetch_addr and pc_f, issues one 64-bit line
// request at a time to the ICU, filters returned data into the instruction
// queue and handles branch redirects (queue flush + stale response drop).
//
// Ports:
//   clk, resetn            clock, async active-low reset
//   exu_ifu_br_taken       redirect pulse; exu_ifu_br_target = new PC
//   exu_ifu_stall_req      blocks pc_f advance
//   iq_not_empty           queue holds a valid line
//   fetch_ahead            queue permits the next line request
//   icu (master)           ICU req/addr/ack/data_valid handshake
//   ifu_iq_data_valid      filtered data-valid into the queue
//   flush_iq               queue flush (same cycle as redirect)
//   pc_f                   PC of the instruction currently presented
//
// Optional: define CPU7_IFU_FETCH_PERF_EN to add perf_fetch_cnt and
// perf_drop_cnt counters/outputs.
module cpu7_ifu_fetch_ctl #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        exu_ifu_br_taken,
  input  logic [31:0] exu_ifu_br_target,
  input  logic        exu_ifu_stall_req,
  input  logic        iq_not_empty,
  input  logic        fetch_ahead,
  cpu7_ifu_fetch_ctl_if.master icu,
  output logic        ifu_iq_data_valid,
  output logic        flush_iq,
`ifdef CPU7_IFU_FETCH_PERF_EN
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_drop_cnt,
`endif
  output logic [31:0] pc_f
);

  typedef enum logic [1:0] {BOOT, REQ, WAIT, HOLD} state_t;

  state_t      state;
  logic        req;
  logic        drop;
  logic [31:0] fetch_addr;

  logic        br;
  logic        dv;
  logic        ack;
  logic [31:0] br_line;
  logic [31:0] br_pc;

  assign br      = exu_ifu_br_taken;
  assign dv      = icu.icu_ifu_data_valid_ic2;
  assign ack     = icu.icu_ifu_ack_ic1;
  assign br_line = {exu_ifu_br_target[31:3], 3'b000};
  assign br_pc   = {exu_ifu_br_target[31:2], 2'b00};

  assign icu.ifu_icu_req_ic1  = req;
  assign icu.ifu_icu_addr_ic1 = fetch_addr;

  // Response is only meaningful while a request is outstanding; a response
  // landing in BOOT/REQ (e.g. left over from before a reset) is ignored.
  assign ifu_iq_data_valid = dv & (state == WAIT) & ~drop & ~br;
  assign flush_iq          = br;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= BOOT;
      req        <= 1'b0;
      drop       <= 1'b0;
      fetch_addr <= {RESET_PC[31:3], 3'b000};
      pc_f       <= RESET_PC;
    end else begin
      // pc_f: redirect wins over sequential advance
      if (br)
        pc_f <= br_pc;
      else if (iq_not_empty && !exu_ifu_stall_req)
        pc_f <= pc_f + 32'd4;

      if (br)
        fetch_addr <= br_line;

      case (state)
        BOOT: begin
          state <= REQ;
          req   <= 1'b1;
        end
        REQ: begin
          if (ack) begin
            state <= WAIT;
            req   <= 1'b0;
            // redirect on the accept cycle: the response now in flight is stale
            if (br) drop <= 1'b1;
          end
        end
        WAIT: begin
          if (dv) begin
            // Response closes the outstanding request; whether it was stale
            // or killed by a same-cycle redirect, nothing remains in flight.
            if (drop || br) begin
              drop  <= 1'b0;
              state <= REQ;
              req   <= 1'b1;
            end else begin
              fetch_addr <= fetch_addr + 32'd8;
              state      <= HOLD;
            end
          end else if (br) begin
            drop <= 1'b1;
          end
        end
        HOLD: begin
          if (br || fetch_ahead || !iq_not_empty) begin
            state <= REQ;
            req   <= 1'b1;
          end
        end
        default: begin
          state <= BOOT;
          req   <= 1'b0;
        end
      endcase
    end
  end

`ifdef CPU7_IFU_FETCH_PERF_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_fetch_cnt <= 32'd0;
      perf_drop_cnt  <= 32'd0;
    end else begin
      if (req && ack)
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (dv && (state == WAIT) && (drop || br))
        perf_drop_cnt <= perf_drop_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cpu7_ifu_fetch_ctl.sv
module tb_cpu7_ifu_fetch_ctl;

  logic        clk;
  logic        resetn;
  logic        br_taken;
  logic [31:0] br_target;
  logic        stall_req;
  logic        iq_ne;
  logic        f_ahead;
  logic        iq_dv;
  logic        flush;
  logic [31:0] pc_f;
`ifdef CPU7_IFU_FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_drop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  cpu7_ifu_fetch_ctl_if icu ();

  cpu7_ifu_fetch_ctl #(.RESET_PC(32'h1c000000)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .exu_ifu_br_taken  (br_taken),
    .exu_ifu_br_target (br_target),
    .exu_ifu_stall_req (stall_req),
    .iq_not_empty      (iq_ne),
    .fetch_ahead       (f_ahead),
    .icu               (icu.master),
    .ifu_iq_data_valid (iq_dv),
    .flush_iq          (flush),
`ifdef CPU7_IFU_FETCH_PERF_EN
    .perf_fetch_cnt    (perf_fetch_cnt),
    .perf_drop_cnt     (perf_drop_cnt),
`endif
    .pc_f              (pc_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        br;
    logic [31:0] tgt;
    logic        stall;
    logic        ne;
    logic        fa;
    logic        ack;
    logic        dv;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_dvo;
    logic        e_flush;
    logic [31:0] e_pc;
  } vec_t;

  vec_t v[26];

  function automatic vec_t mk(logic br, logic [31:0] tgt, logic stall, logic ne,
                              logic fa, logic ack, logic dv, logic e_req,
                              logic [31:0] e_addr, logic e_dvo, logic e_flush,
                              logic [31:0] e_pc);
    vec_t r;
    r.br = br; r.tgt = tgt; r.stall = stall; r.ne = ne; r.fa = fa;
    r.ack = ack; r.dv = dv; r.e_req = e_req; r.e_addr = e_addr;
    r.e_dvo = e_dvo; r.e_flush = e_flush; r.e_pc = e_pc;
    return r;
  endfunction

  initial begin
    //        br tgt           st ne fa ak dv | req addr          dvo fl pc
    v[0]  = mk(0, 32'h0,        0, 0, 0, 0, 0,  0, 32'h1c000000, 0, 0, 32'h1c000000); // BOOT
    v[1]  = mk(0, 32'h0,        0, 0, 0, 1, 0,  1, 32'h1c000000, 0, 0, 32'h1c000000); // REQ+ack
    v[2]  = mk(0, 32'h0,        0, 0, 0, 0, 0,  0, 32'h1c000000, 0, 0, 32'h1c000000); // WAIT
    v[3]  = mk(0, 32'h0,        0, 0, 0, 0, 1,  0, 32'h1c000000, 1, 0, 32'h1c000000); // data
    v[4]  = mk(0, 32'h0,        0, 1, 0, 0, 0,  0, 32'h1c000008, 0, 0, 32'h1c000000); // HOLD
    v[5]  = mk(0, 32'h0,        1, 1, 0, 0, 0,  0, 32'h1c000008, 0, 0, 32'h1c000004); // stall
    v[6]  = mk(0, 32'h0,        0, 1, 1, 0, 0,  0, 32'h1c000008, 0, 0, 32'h1c000004); // fetch_ahead
    v[7]  = mk(0, 32'h0,        0, 1, 0, 0, 0,  1, 32'h1c000008, 0, 0, 32'h1c000008); // REQ no ack
    v[8]  = mk(0, 32'h0,        0, 1, 0, 1, 0,  1, 32'h1c000008, 0, 0, 32'h1c00000c); // ack
    v[9]  = mk(1, 32'h1c000024, 0, 0, 0, 0, 0,  0, 32'h1c000008, 0, 1, 32'h1c000010); // br in WAIT
    v[10] = mk(0, 32'h0,        0, 0, 0, 0, 1,  0, 32'h1c000020, 0, 0, 32'h1c000024); // stale dropped
    v[11] = mk(1, 32'h1c000104, 0, 0, 0, 0, 0,  1, 32'h1c000020, 0, 1, 32'h1c000024); // br in REQ
    v[12] = mk(0, 32'h0,        0, 0, 0, 1, 0,  1, 32'h1c000100, 0, 0, 32'h1c000104); // new addr
    v[13] = mk(1, 32'h1c000208, 0, 0, 0, 0, 1,  0, 32'h1c000100, 0, 1, 32'h1c000104); // dv+br
    v[14] = mk(0, 32'h0,        0, 0, 0, 1, 0,  1, 32'h1c000208, 0, 0, 32'h1c000208);
    v[15] = mk(0, 32'h0,        0, 0, 0, 0, 1,  0, 32'h1c000208, 1, 0, 32'h1c000208); // drop was 0
    v[16] = mk(0, 32'h0,        0, 0, 0, 0, 0,  0, 32'h1c000210, 0, 0, 32'h1c000208); // drained
    v[17] = mk(1, 32'h1c000300, 0, 0, 0, 1, 0,  1, 32'h1c000210, 0, 1, 32'h1c000208); // br+ack
    v[18] = mk(1, 32'h1c000400, 0, 0, 0, 0, 0,  0, 32'h1c000300, 0, 1, 32'h1c000300); // br, drop set
    v[19] = mk(0, 32'h0,        0, 0, 0, 0, 1,  0, 32'h1c000400, 0, 0, 32'h1c000400); // stale dropped
    v[20] = mk(0, 32'h0,        0, 0, 0, 1, 0,  1, 32'h1c000400, 0, 0, 32'h1c000400);
    v[21] = mk(0, 32'h0,        0, 0, 0, 0, 1,  0, 32'h1c000400, 1, 0, 32'h1c000400);
    v[22] = mk(1, 32'hfffffffe, 0, 0, 0, 0, 0,  0, 32'h1c000408, 0, 1, 32'h1c000400); // br in HOLD
    v[23] = mk(0, 32'h0,        0, 1, 0, 1, 0,  1, 32'hfffffff8, 0, 0, 32'hfffffffc);
    v[24] = mk(0, 32'h0,        0, 0, 0, 0, 1,  0, 32'hfffffff8, 1, 0, 32'h00000000); // pc wrapped
    v[25] = mk(0, 32'h0,        0, 1, 0, 0, 0,  0, 32'h00000000, 0, 0, 32'h00000000); // addr wrapped

    resetn = 1'b0; br_taken = 1'b0; br_target = '0; stall_req = 1'b0;
    iq_ne = 1'b0; f_ahead = 1'b0;
    icu.icu_ifu_ack_ic1 = 1'b0; icu.icu_ifu_data_valid_ic2 = 1'b0;
    repeat (3) @(posedge clk);
    #2 resetn = 1'b1;

    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      br_taken = v[i].br; br_target = v[i].tgt; stall_req = v[i].stall;
      iq_ne = v[i].ne; f_ahead = v[i].fa;
      icu.icu_ifu_ack_ic1 = v[i].ack; icu.icu_ifu_data_valid_ic2 = v[i].dv;
      #1;
      chk($sformatf("v%0d req", i),   {31'd0, icu.ifu_icu_req_ic1}, {31'd0, v[i].e_req});
      chk($sformatf("v%0d addr", i),  icu.ifu_icu_addr_ic1, v[i].e_addr);
      chk($sformatf("v%0d dvo", i),   {31'd0, iq_dv}, {31'd0, v[i].e_dvo});
      chk($sformatf("v%0d flush", i), {31'd0, flush}, {31'd0, v[i].e_flush});
      chk($sformatf("v%0d pc", i),    pc_f, v[i].e_pc);
    end

`ifdef CPU7_IFU_FETCH_PERF_EN
    @(negedge clk);
    chk("perf_fetch", perf_fetch_cnt, 32'd7);
    chk("perf_drop",  perf_drop_cnt,  32'd3);
`endif

    // Reset asserted while a request is outstanding
    @(negedge clk);
    br_taken = 1'b0; stall_req = 1'b0; iq_ne = 1'b0; f_ahead = 1'b1;
    icu.icu_ifu_ack_ic1 = 1'b0; icu.icu_ifu_data_valid_ic2 = 1'b0;
    @(negedge clk);
    f_ahead = 1'b0;
    #1 chk("seq req before reset", {31'd0, icu.ifu_icu_req_ic1}, 32'd1);
    icu.icu_ifu_ack_ic1 = 1'b1;
    @(negedge clk);
    icu.icu_ifu_ack_ic1 = 1'b0;
    #1 chk("seq wait req", {31'd0, icu.ifu_icu_req_ic1}, 32'd0);
    #1 resetn = 1'b0;
    #1;
    chk("rst req",  {31'd0, icu.ifu_icu_req_ic1}, 32'd0);
    chk("rst addr", icu.ifu_icu_addr_ic1, 32'h1c000000);
    chk("rst pc",   pc_f, 32'h1c000000);
    chk("rst flush", {31'd0, flush}, 32'd0);
    icu.icu_ifu_data_valid_ic2 = 1'b1;
    #1 chk("rst dvo", {31'd0, iq_dv}, 32'd0);
    @(posedge clk);
    #2 resetn = 1'b1;
    @(negedge clk);
    #1;
    chk("post-rst boot req", {31'd0, icu.ifu_icu_req_ic1}, 32'd0);
    chk("post-rst boot dvo", {31'd0, iq_dv}, 32'd0);
    @(negedge clk);
    #1;
    chk("post-rst req",  {31'd0, icu.ifu_icu_req_ic1}, 32'd1);
    chk("post-rst addr", icu.ifu_icu_addr_ic1, 32'h1c000000);
    chk("post-rst stale dvo", {31'd0, iq_dv}, 32'd0);
    icu.icu_ifu_data_valid_ic2 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
